xif_copro_issue_resp: RTL and testbench

- Coprocessor-side responder for the CV-X-IF issue, commit and result interfaces.
- Decodes each offloaded instruction against the coprocessor instruction set: BITREV, ROTRIGHT, ROTLEFT. All three use opcode 0101011 and funct3 111, with funct7 0000010, 0000011 and 0000100 respectively.
- Accepts or rejects each offer, holds one accepted instruction until commit, executes it, and returns results through a small result FIFO with valid/ready back-pressure.

---
 rtl/xif_copro_issue_resp.sv | 219 +++++++++++++++++++++
 tb/tb_xif_copro_issue_resp.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_copro_issue_resp.sv
// CV-X-IF coprocessor responder: decodes BITREV/ROTRIGHT/ROTLEFT offers, holds one
// accepted instruction until commit, and returns results through a small FIFO.
module xif_copro_issue_resp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = $clog2(RES_DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef enum logic [1:0] {
        OP_BITREV,
        OP_ROTR,
        OP_ROTL
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COMMIT,
        COMMITTED
    } state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        logic [XLEN-1:0]     data;
    } res_t;

    state_e              state;
    op_e                 pend_op;
    logic [ID_WIDTH-1:0] pend_id;
    logic [4:0]          pend_rd;
    logic [XLEN-1:0]     pend_rs1;
    logic [SHW-1:0]      pend_amt;

    logic                match;
    op_e                 dec_op;
    logic                ops_ok;
    logic                hs;
    logic                commit_hit_issue;
    logic                commit_hit_pend;

    op_e                 exec_op;
    logic [XLEN-1:0]     exec_a;
    logic [SHW-1:0]      exec_amt;
    logic [2*XLEN-1:0]   rot_r;
    logic [2*XLEN-1:0]   rot_l;
    res_t                entry;

    logic                push;
    logic                pop;
    logic                full;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [PW-1:0]       rptr_next;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    res_t                mem [RES_DEPTH];
    res_t                head_next;

    // Register-field bits of the instruction and the upper rs2 bits never affect the result.
    logic                unused_bits;
    assign unused_bits = ^{issue_instr_i[24:15], issue_rs2_i[XLEN-1:SHW]};

    always_comb begin
        match  = 1'b0;
        dec_op = OP_BITREV;
        if (issue_instr_i[6:0] == 7'b0101011 && issue_instr_i[14:12] == 3'b111) begin
            case (issue_instr_i[31:25])
                7'b0000010: begin match = 1'b1; dec_op = OP_BITREV; end
                7'b0000011: begin match = 1'b1; dec_op = OP_ROTR;   end
                7'b0000100: begin match = 1'b1; dec_op = OP_ROTL;   end
                default:    ;
            endcase
        end
        ops_ok = issue_rs_valid_i[0] && (dec_op == OP_BITREV || issue_rs_valid_i[1]);
    end

    assign issue_ready_o     = (state == IDLE) && (!match || ops_ok);
    assign hs                = issue_valid_i && issue_ready_o && match;
    assign issue_accept_o    = hs;
    assign issue_writeback_o = hs;

    assign commit_hit_issue = commit_valid_i && (commit_id_i == issue_id_i);
    assign commit_hit_pend  = commit_valid_i && (commit_id_i == pend_id);

    // In IDLE the execute path works on the live offer so an immediate commit can push directly.
    always_comb begin
        exec_op  = (state == IDLE) ? dec_op : pend_op;
        exec_a   = (state == IDLE) ? issue_rs1_i : pend_rs1;
        exec_amt = (state == IDLE) ? issue_rs2_i[SHW-1:0] : pend_amt;
        rot_r    = {exec_a, exec_a} >> exec_amt;
        rot_l    = {exec_a, exec_a} << exec_amt;
        entry.id = (state == IDLE) ? issue_id_i : pend_id;
        entry.rd = (state == IDLE) ? issue_instr_i[11:7] : pend_rd;
        entry.data = '0;
        case (exec_op)
            OP_BITREV: begin
                for (int unsigned i = 0; i < XLEN; i++) begin
                    entry.data[i] = exec_a[XLEN-1-i];
                end
            end
            OP_ROTR: entry.data = rot_r[XLEN-1:0];
            OP_ROTL: entry.data = rot_l[2*XLEN-1:XLEN];
            default: entry.data = exec_a;
        endcase
    end

    assign pop  = result_valid_o && result_ready_i;
    assign full = (count == CW'(RES_DEPTH));

    always_comb begin
        push = 1'b0;
        case (state)
            IDLE:        push = hs && commit_hit_issue && !commit_kill_i && !full;
            WAIT_COMMIT: push = commit_hit_pend && !commit_kill_i && !full;
            COMMITTED:   push = !full || pop;
            default:     push = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            pend_op  <= OP_BITREV;
            pend_id  <= '0;
            pend_rd  <= '0;
            pend_rs1 <= '0;
            pend_amt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        pend_op  <= dec_op;
                        pend_id  <= issue_id_i;
                        pend_rd  <= issue_instr_i[11:7];
                        pend_rs1 <= issue_rs1_i;
                        pend_amt <= issue_rs2_i[SHW-1:0];
                        if (!commit_hit_issue) begin
                            state <= WAIT_COMMIT;
                        end else if (!commit_kill_i && full) begin
                            state <= COMMITTED;
                        end
                    end
                end
                WAIT_COMMIT: begin
                    if (commit_hit_pend) begin
                        state <= (commit_kill_i || !full) ? IDLE : COMMITTED;
                    end
                end
                COMMITTED: begin
                    if (push) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rptr_next  = pop ? rptr + PW'(1) : rptr;
    assign count_next = count + CW'(push) - CW'(pop);
    // The new entry becomes the head when it lands at the next read position.
    assign head_next  = (push && wptr == rptr_next) ? entry : mem[rptr_next];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            rptr           <= rptr_next;
            count          <= count_next;
            result_valid_o <= (count_next != '0);
            result_id_o    <= head_next.id;
            result_rd_o    <= head_next.rd;
            result_data_o  <= head_next.data;
        end
    end

    assign result_we_o = result_valid_o;

endmodule

// File: tb/tb_xif_copro_issue_resp.sv
// Directed and randomized checks of xif_copro_issue_resp against a queue-based
// model of the issue slot and the in-order result stream.
module tb_xif_copro_issue_resp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDW   = 4;
    localparam int unsigned DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            issue_valid;
    logic            issue_ready;
    logic [31:0]     issue_instr;
    logic [IDW-1:0]  issue_id;
    logic [XLEN-1:0] issue_rs1;
    logic [XLEN-1:0] issue_rs2;
    logic [1:0]      issue_rs_valid;
    logic            issue_accept;
    logic            issue_writeback;
    logic            commit_valid;
    logic [IDW-1:0]  commit_id;
    logic            commit_kill;
    logic            result_valid;
    logic            result_ready;
    logic [IDW-1:0]  result_id;
    logic [4:0]      result_rd;
    logic [XLEN-1:0] result_data;
    logic            result_we;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xif_copro_issue_resp #(
        .XLEN      (XLEN),
        .ID_WIDTH  (IDW),
        .RES_DEPTH (DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs1_i       (issue_rs1),
        .issue_rs2_i       (issue_rs2),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_writeback),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id),
        .result_rd_o       (result_rd),
        .result_data_o     (result_data),
        .result_we_o       (result_we)
    );

    typedef struct {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    res_t mq[$];
    bit   m_pend;
    bit   m_comm;
    res_t m_slot;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd7, 5'd3, f3, rd, opc};
    endfunction

    function automatic logic [31:0] cop(input int k, input logic [4:0] rd);
        return mk(7'(k + 1), rd, 3'b111, 7'b0101011);
    endfunction

    // 0: not a coprocessor instruction, 1: BITREV, 2: ROTRIGHT, 3: ROTLEFT
    function automatic int kind_of(input logic [31:0] ins);
        if (ins[6:0] != 7'b0101011 || ins[14:12] != 3'b111) return 0;
        case (ins[31:25])
            7'b0000010: return 1;
            7'b0000011: return 2;
            7'b0000100: return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_exec(input int k, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned n;
        r = a;
        n = b % 32;
        if (k == 1) begin
            for (int i = 0; i < 32; i++) r[i] = a[31-i];
        end else begin
            repeat (n) r = (k == 2) ? {r[0], r[31:1]} : {r[30:0], r[31]};
        end
        return r;
    endfunction

    function automatic bit exp_ready();
        int k;
        if (m_pend) return 1'b0;
        k = kind_of(issue_instr);
        if (k == 0) return 1'b1;
        return issue_rs_valid[0] && (k == 1 || issue_rs_valid[1]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_results();
        check("result_valid", 64'(result_valid), 64'(mq.size() > 0));
        check("result_we", 64'(result_we), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("result_id", 64'(result_id), 64'(mq[0].id));
            check("result_rd", 64'(result_rd), 64'(mq[0].rd));
            check("result_data", 64'(result_data), 64'(mq[0].data));
        end
    endtask

    // Inputs are set before the call; checks handshake outputs, advances the model one clock.
    task automatic tick();
        bit   rdy, hs, pop, full, push;
        res_t e;
        #1;
        rdy = exp_ready();
        hs  = issue_valid && rdy && (kind_of(issue_instr) != 0);
        check("issue_ready", 64'(issue_ready), 64'(rdy));
        check("issue_accept", 64'(issue_accept), 64'(hs));
        check("issue_writeback", 64'(issue_writeback), 64'(hs));
        pop  = (mq.size() > 0) && result_ready;
        full = (mq.size() == DEPTH);
        push = 1'b0;
        e    = m_slot;
        if (m_pend && m_comm) begin
            if (!full || pop) begin
                push = 1'b1;
                m_pend = 1'b0;
            end
        end else if (m_pend) begin
            if (commit_valid && commit_id == m_slot.id) begin
                if (commit_kill) m_pend = 1'b0;
                else if (!full) begin
                    push = 1'b1;
                    m_pend = 1'b0;
                end else m_comm = 1'b1;
            end
        end else if (hs) begin
            e.id   = issue_id;
            e.rd   = issue_instr[11:7];
            e.data = ref_exec(kind_of(issue_instr), issue_rs1, issue_rs2);
            if (commit_valid && commit_id == issue_id) begin
                if (!commit_kill) begin
                    if (!full) push = 1'b1;
                    else begin
                        m_slot = e;
                        m_pend = 1'b1;
                        m_comm = 1'b1;
                    end
                end
            end else begin
                m_slot = e;
                m_pend = 1'b1;
                m_comm = 1'b0;
            end
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(e);
        @(posedge clk);
        #1;
        check_results();
    endtask

    task automatic offer(input logic [31:0] ins, input logic [IDW-1:0] id,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv);
        issue_valid    = 1'b1;
        issue_instr    = ins;
        issue_id       = id;
        issue_rs1      = a;
        issue_rs2      = b;
        issue_rs_valid = rsv;
    endtask

    task automatic commit(input bit v, input logic [IDW-1:0] id, input bit kill);
        commit_valid = v;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    task automatic idle_in();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic [31:0] ins;

        rst_ni = 1'b0;
        issue_instr = '0; issue_id = '0; issue_rs1 = '0; issue_rs2 = '0;
        issue_rs_valid = '0; commit_id = '0; result_ready = 1'b0;
        idle_in();
        m_pend = 1'b0; m_comm = 1'b0; m_slot = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_id", 64'(result_id), 64'd0);
        check("reset_rd", 64'(result_rd), 64'd0);
        check("reset_data", 64'(result_data), 64'd0);
        rst_ni = 1'b1;

        // BITREV with immediate commit: result one cycle after the handshake
        offer(cop(1, 5'd9), 4'd3, 32'h0000_0001, 32'h0, 2'b01);
        commit(1'b1, 4'd3, 1'b0);
        tick();
        check("t1_data", 64'(result_data), 64'h8000_0000);
        check("t1_id", 64'(result_id), 64'd3);
        check("t1_rd", 64'(result_rd), 64'd9);
        idle_in(); result_ready = 1'b1;
        tick();

        // ROTRIGHT then ROTLEFT, results in order
        result_ready = 1'b0;
        offer(cop(2, 5'd4), 4'd1, 32'h8000_0001, 32'h24, 2'b11); commit(1'b1, 4'd1, 1'b0);
        tick();
        offer(cop(3, 5'd5), 4'd2, 32'h8000_0001, 32'h1, 2'b11); commit(1'b1, 4'd2, 1'b0);
        tick();
        idle_in();
        tick();
        check("t2_first", 64'(result_data), 64'h1800_0000);
        result_ready = 1'b1;
        tick();
        check("t2_second", 64'(result_data), 64'h0000_0003);
        tick();

        // Non-coprocessor offer, then a rotate missing rs2
        offer(mk(7'b0, 5'd10, 3'b000, 7'b0110011), 4'd6, 32'h1, 32'h2, 2'b11);
        tick();
        offer(cop(2, 5'd11), 4'd7, 32'h1234_5678, 32'h8, 2'b01);
        tick();
        tick();
        issue_rs_valid = 2'b11; commit(1'b1, 4'd7, 1'b0);
        tick();
        idle_in();
        tick();
        tick();

        // Commit for another id is ignored; kill frees the slot
        offer(cop(1, 5'd12), 4'd5, 32'hF0F0_0001, 32'h0, 2'b01);
        tick();
        offer(cop(1, 5'd13), 4'd6, 32'h1, 32'h0, 2'b01); commit(1'b1, 4'd4, 1'b0);
        tick();
        issue_valid = 1'b0; commit(1'b1, 4'd5, 1'b1);
        tick();
        offer(cop(3, 5'd14), 4'd8, 32'hA5A5_0000, 32'h10, 2'b11); commit(1'b1, 4'd8, 1'b0);
        tick();
        idle_in();
        tick();
        tick();

        // Back-pressure: third committed result waits for room
        result_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(cop(1, 5'(16 + i)), 4'(8 + i), 32'(i + 1), 32'h0, 2'b01);
            commit(1'b1, 4'(8 + i), 1'b0);
            tick();
        end
        offer(cop(1, 5'd20), 4'd11, 32'h5, 32'h0, 2'b01); commit(1'b0, 4'd11, 1'b0);
        tick();
        idle_in();
        tick();
        check("t5_stall_id", 64'(result_id), 64'd8);
        check("t5_stall_data", 64'(result_data), 64'h8000_0000);
        result_ready = 1'b1;
        repeat (4) tick();

        // Reset while an instruction waits for commit and one result is queued
        result_ready = 1'b0;
        offer(cop(1, 5'd21), 4'd1, 32'h3, 32'h0, 2'b01); commit(1'b1, 4'd1, 1'b0);
        tick();
        offer(cop(2, 5'd22), 4'd2, 32'h3, 32'h1, 2'b11); commit(1'b0, 4'd0, 1'b0);
        tick();
        idle_in();
        rst_ni = 1'b0;
        #2;
        check("rst_mid_valid", 64'(result_valid), 64'd0);
        check("rst_mid_id", 64'(result_id), 64'd0);
        check("rst_mid_data", 64'(result_data), 64'd0);
        mq.delete();
        m_pend = 1'b0;
        m_comm = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        offer(cop(3, 5'd23), 4'd4, 32'h0000_00FF, 32'h4, 2'b11); commit(1'b1, 4'd4, 1'b0);
        tick();
        idle_in(); result_ready = 1'b1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            f7 = 7'b0000010; f3 = 3'b111; opc = 7'b0101011;
            case ($urandom_range(0, 5))
                0: f7 = 7'b0000010;
                1: f7 = 7'b0000011;
                2: f7 = 7'b0000100;
                3: opc = 7'b0110011;
                4: f7 = 7'b0000101;
                default: f3 = 3'b110;
            endcase
            ins = mk(f7, 5'($urandom), f3, opc);
            ins[24:15] = 10'($urandom);
            offer(ins, 4'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom));
            issue_valid = ($urandom_range(0, 3) != 0);
            commit(($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 3) != 0) ? (m_pend ? m_slot.id : issue_id) : 4'($urandom),
                   ($urandom_range(0, 4) == 0));
            result_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        idle_in();
        result_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
